// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus port arbiter.
//   arb_state_t  : arbiter sequencing states
//   hb_port_t    : upstream master identifiers (encoding doubles as request bit index)
//   hb_cmd_t     : command payload forwarded to the transaction sequencer
package hyperbus_pkg;

    localparam int unsigned HB_ADDR_W = 32;
    localparam int unsigned HB_DATA_W = 32;

    localparam logic [HB_DATA_W-1:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } arb_state_t;

    typedef enum logic {
        PORT_CSR = 1'b0,
        PORT_S0  = 1'b1
    } hb_port_t;

    typedef struct packed {
        logic                 reg_space;
        logic                 write;
        logic [HB_ADDR_W-1:0] addr;
        logic [HB_DATA_W-1:0] wdata;
    } hb_cmd_t;

    // The port that is not p.
    function automatic hb_port_t other_port(input hb_port_t p);
        return (p == PORT_CSR) ? PORT_S0 : PORT_CSR;
    endfunction

endpackage

// File: rtl/hb_rr_pick.sv
// Two-way round-robin picker.
//   req[1:0] : pending requests, bit index = hb_port_t encoding
//   last     : port granted most recently
//   grant    : chosen port; only meaningful when |req
module hb_rr_pick
    import hyperbus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    hb_port_t fav;

    // Favour the port not granted last; fall back to the other when idle.
    always_comb begin
        fav   = other_port(hb_port_t'(last));
        grant = req[fav] ? fav : other_port(fav);
    end

endmodule

// File: rtl/hyperbus_port_arbiter.sv
// Shares one HyperBus transaction sequencer between the CSR and s0 Avalon-MM
// masters. One transaction in flight at a time, round-robin grant, watchdog
// abort for responses that never arrive.
//   clk, rst                : clock, synchronous active-high reset
//   csr_* / s0_*            : Avalon-MM slave ports for the two masters
//   cmd_*                   : command to the sequencer (valid/ready handshake)
//   cmd_abort               : one-cycle abort pulse on watchdog expiry
//   rsp_valid, rsp_data     : sequencer completion and read data
//   err_clr, timeout_err    : sticky abort flag and its clear
module hyperbus_port_arbiter
    import hyperbus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] csr_address,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic        csr_waitrequest,
    output logic [31:0] csr_readdata,
    output logic        csr_readdatavalid,

    input  logic [31:0] s0_address,
    input  logic        s0_read,
    input  logic        s0_write,
    input  logic [31:0] s0_writedata,
    output logic        s0_waitrequest,
    output logic [31:0] s0_readdata,
    output logic        s0_readdatavalid,

    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_reg,
    output logic        cmd_write,
    output logic [31:0] cmd_addr,
    output logic [31:0] cmd_wdata,
    output logic        cmd_abort,

    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,

    input  logic        err_clr,
    output logic        timeout_err
);

    localparam int unsigned       WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t      state_q, state_d;
    hb_port_t        gnt_q, gnt_d;
    hb_port_t        last_q, last_d;
    hb_cmd_t         cmd_q, cmd_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            cmd_abort_q, cmd_abort_d;
    logic            terr_q, terr_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [31:0]     csr_rd_q, csr_rd_d, s0_rd_q, s0_rd_d;
    logic            csr_rdv_q, csr_rdv_d, s0_rdv_q, s0_rdv_d;

    logic [1:0]      req;
    logic            pick;
    logic            accept;
    logic            ret_valid;
    logic [31:0]     ret_data;

    assign req = {s0_read | s0_write, csr_read | csr_write};

    hb_rr_pick u_pick (
        .req   (req),
        .last  (last_q),
        .grant (pick)
    );

    // Acceptance is combinational so the master sees it in the handshake cycle.
    assign accept          = (state_q == ISSUE) && cmd_ready;
    assign csr_waitrequest = !(accept && (gnt_q == PORT_CSR));
    assign s0_waitrequest  = !(accept && (gnt_q == PORT_S0));

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        cmd_abort_d = 1'b0;
        terr_d      = terr_q & ~err_clr;
        wd_d        = wd_q;
        csr_rd_d    = csr_rd_q;
        s0_rd_d     = s0_rd_q;
        csr_rdv_d   = 1'b0;
        s0_rdv_d    = 1'b0;
        ret_valid   = 1'b0;
        ret_data    = '0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d       = hb_port_t'(pick);
                    last_d      = hb_port_t'(pick);
                    cmd_valid_d = 1'b1;
                    state_d     = ISSUE;
                    if (hb_port_t'(pick) == PORT_CSR) begin
                        cmd_d.reg_space = 1'b1;
                        cmd_d.write     = csr_write;
                        cmd_d.addr      = csr_address;
                        cmd_d.wdata     = csr_writedata;
                    end else begin
                        cmd_d.reg_space = 1'b0;
                        cmd_d.write     = s0_write;
                        cmd_d.addr      = s0_address;
                        cmd_d.wdata     = s0_writedata;
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    wd_d        = '0;
                    state_d     = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response in the expiry cycle still counts as a completion.
                if (rsp_valid) begin
                    ret_valid = !cmd_q.write;
                    ret_data  = rsp_data;
                    wd_d      = '0;
                    state_d   = IDLE;
                end else if (wd_q == WD_LAST) begin
                    cmd_abort_d = 1'b1;
                    terr_d      = 1'b1;
                    ret_valid   = !cmd_q.write;
                    ret_data    = TIMEOUT_DATA;
                    wd_d        = '0;
                    state_d     = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (ret_valid) begin
            if (gnt_q == PORT_CSR) begin
                csr_rdv_d = 1'b1;
                csr_rd_d  = ret_data;
            end else begin
                s0_rdv_d  = 1'b1;
                s0_rd_d   = ret_data;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= PORT_CSR;
            last_q      <= PORT_S0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_abort_q <= 1'b0;
            terr_q      <= 1'b0;
            wd_q        <= '0;
            csr_rd_q    <= '0;
            s0_rd_q     <= '0;
            csr_rdv_q   <= 1'b0;
            s0_rdv_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_abort_q <= cmd_abort_d;
            terr_q      <= terr_d;
            wd_q        <= wd_d;
            csr_rd_q    <= csr_rd_d;
            s0_rd_q     <= s0_rd_d;
            csr_rdv_q   <= csr_rdv_d;
            s0_rdv_q    <= s0_rdv_d;
        end
    end

    assign cmd_valid         = cmd_valid_q;
    assign cmd_reg           = cmd_q.reg_space;
    assign cmd_write         = cmd_q.write;
    assign cmd_addr          = cmd_q.addr;
    assign cmd_wdata         = cmd_q.wdata;
    assign cmd_abort         = cmd_abort_q;
    assign timeout_err       = terr_q;
    assign csr_readdata      = csr_rd_q;
    assign csr_readdatavalid = csr_rdv_q;
    assign s0_readdata       = s0_rd_q;
    assign s0_readdatavalid  = s0_rdv_q;

endmodule
